reg_array_mp: RTL and testbench
===============================

Name: reg_array_mp

Overview:
- Parametrised multi-port integer register file; the successor of the single-write, dual-read register array.
- Sits between decode (read ports) and the writeback stages; supports configurable read/write port counts, width and depth.
- Adds async reset, write-to-read bypass, write-port priority, and a per-register pending-writeback scoreboard (busy bits) used by the hazard unit.

Parameters:
XLEN, 32, data width of each register
NUM_REGS, 32, number of architectural registers including x0; power of two
AW, 5, register index width, $clog2(NUM_REGS)
NUM_RD, 2, number of read ports
NUM_WR, 2, number of write ports
BYPASS_EN, 1, 1 = same-cycle write data forwarded to matching reads
SP_INDEX, 2, register loaded with SP_RESET_VAL on reset
SP_RESET_VAL, 32'd1024, reset value of register SP_INDEX

Ports:
CLK  input  1  clock, rising edge
RST_N  input  1  asynchronous active-low reset
RS_SEL  input  NUM_RD*AW  read indices, port k at [k*AW +: AW]
RS_DATAOUT  output  NUM_RD*XLEN  read data, port k at [k*XLEN +: XLEN]
RS_BUSY  output  NUM_RD  busy bit of the register selected on port k
WB_VALID  input  NUM_WR  write enable per write port
WB_SEL  input  NUM_WR*AW  write indices
WB_DATA  input  NUM_WR*XLEN  write data
ISSUE_VALID  input  1  an instruction with destination ISSUE_RD enters the pipeline
ISSUE_RD  input  AW  destination register of the issuing instruction
FLUSH  input  1  pipeline flush; clears all busy bits
PARITY_ERR  output  NUM_RD  parity mismatch on read port k (see Optional Feature)

Behaviour:
- Reset (RST_N low, asynchronous): all registers 0 except REGISTER[SP_INDEX] = SP_RESET_VAL; all busy bits 0. Outputs are combinational from state, so immediately after reset RS_DATAOUT = 0 (or SP_RESET_VAL for the SP index), RS_BUSY = 0, PARITY_ERR = 0.
- x0: reads of index 0 always return 0 with RS_BUSY 0. Writes and issues to index 0 are discarded.
- Write: on the rising edge, each port with WB_VALID set writes WB_DATA to WB_SEL.
  - If several ports target the same index, the highest-numbered port wins.
- Read: combinational, zero latency.
  - BYPASS_EN=1: if any valid write port targets RS_SEL[k] (k != 0) this cycle, RS_DATAOUT[k] returns the winning port's WB_DATA. Otherwise it returns stored data.
  - BYPASS_EN=0: reads return stored data only; write data is visible the cycle after the edge.
- Scoreboard, evaluated on the rising edge:
  - A valid writeback to index r clears busy[r].
  - ISSUE_VALID sets busy[ISSUE_RD].
  - Set has priority over clear when both target the same index in the same cycle, because the newer producer is outstanding.
  - FLUSH clears all busy bits and overrides a same-cycle ISSUE_VALID.
  - Writes are still performed during FLUSH.
- RS_BUSY[k] = busy[RS_SEL[k]] AND NOT (a valid write to RS_SEL[k] this cycle, when BYPASS_EN=1). The bypassed value is final, so the reader need not stall.
- Reset asserted mid-operation: all writes, issues and flushes in flight are lost, and state returns to its reset values.

Optional Feature:
- Macro REG_ARRAY_PARITY_EN.
- Defined:
  - Each entry stores one extra even-parity bit computed from the written data.
  - PARITY_ERR[k] = recomputed parity of the stored data XOR the stored parity bit, for k reading a non-zero, non-bypassed index.
  - Reset values are stored with correct parity.
  - Bypassed and x0 reads report 0.
- Undefined: no parity storage; PARITY_ERR tied to 0 and the port retained.

Decomposition:
- Shared package reg_array_pkg holds the XLEN / NUM_REGS / AW defaults, the SP_INDEX / SP_RESET_VAL constants, and the reg_idx_t and xdata_t typedefs.
- One natural sub-module: reg_array_scoreboard, which holds the busy bits, set/clear/flush priority and the RS_BUSY lookup. The data array and bypass mux stay in the top module.

Test Plan:
- Reset: hold RST_N low, release -> RS_SEL={5'd2,5'd1} gives RS_DATAOUT={32'd1024,32'd0}, RS_BUSY=0.
- Dual write conflict: WB_VALID=2'b11, both WB_SEL=5'd7, data 0xAAAA0000 (port0) and 0x5555FFFF (port1) -> next cycle x7 reads 0x5555FFFF. Same cycle with BYPASS_EN=1 -> reads also 0x5555FFFF.
- x0: write 0xDEADBEEF to x0 and issue rd=0 -> x0 reads 0, RS_BUSY=0.
- Scoreboard: issue rd=5 -> RS_BUSY=1 next cycle. Writeback x5=0x12 -> same cycle RS_BUSY=0 with data 0x12 (bypass), stored thereafter. Issue and writeback of x9 in the same cycle -> busy[9]=1.
- Flush: issue x3, x4, then FLUSH together with issue of x6 -> all busy bits 0 after the edge.
- Parity (REG_ARRAY_PARITY_EN): write x10=0x1, force-flip bit 0 of the stored entry via hierarchical deposit -> PARITY_ERR for that port = 1. Unmodified entries read PARITY_ERR=0.

Source files
------------

// File: rtl/reg_array_pkg.sv
// rtl/reg_array_pkg.sv - shared defaults and types for the multi-port register array
package reg_array_pkg;

  localparam int XLEN_DEF     = 32;
  localparam int NUM_REGS_DEF = 32;
  localparam int AW_DEF       = $clog2(NUM_REGS_DEF);
  localparam int NUM_RD_DEF   = 2;
  localparam int NUM_WR_DEF   = 2;
  localparam int SP_INDEX_DEF = 2;
  localparam logic [XLEN_DEF-1:0] SP_RESET_VAL_DEF = 32'd1024;

  typedef logic [AW_DEF-1:0]   reg_idx_t;
  typedef logic [XLEN_DEF-1:0] xdata_t;

endpackage

// File: rtl/reg_array_scoreboard.sv
// rtl/reg_array_scoreboard.sv - pending-writeback busy bits and per-read-port busy lookup
module reg_array_scoreboard
  import reg_array_pkg::*;
#(
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int AW        = AW_DEF,
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int BYPASS_EN = 1
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [NUM_RD*AW-1:0] RS_SEL,
  input  logic [NUM_WR-1:0]    WB_VALID,
  input  logic [NUM_WR*AW-1:0] WB_SEL,
  input  logic                 ISSUE_VALID,
  input  logic [AW-1:0]        ISSUE_RD,
  input  logic                 FLUSH,
  output logic [NUM_RD-1:0]    RS_BUSY
);

  logic [NUM_REGS-1:0] busy_q;
  logic [NUM_REGS-1:0] busy_d;

  // Next busy state: clears from writeback, then set from issue (newer producer wins), flush wipes all
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NUM_WR; p++) begin
      if (WB_VALID[p]) busy_d[WB_SEL[p*AW +: AW]] = 1'b0;
    end
    if (ISSUE_VALID) busy_d[ISSUE_RD] = 1'b1;
    if (FLUSH) busy_d = '0;
    busy_d[0] = 1'b0;
  end

  // Busy bit storage
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) busy_q <= '0;
    else        busy_q <= busy_d;
  end

  // Busy lookup per read port; a same-cycle bypassed write makes the operand final
  always_comb begin
    logic [AW-1:0] sel;
    logic          wr_hit;
    RS_BUSY = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      sel    = RS_SEL[k*AW +: AW];
      wr_hit = 1'b0;
      for (int p = 0; p < NUM_WR; p++) begin
        if (WB_VALID[p] && (WB_SEL[p*AW +: AW] == sel)) wr_hit = 1'b1;
      end
      RS_BUSY[k] = (sel != '0) && busy_q[sel] && !((BYPASS_EN != 0) && wr_hit);
    end
  end

endmodule

// File: rtl/reg_array_mp.sv
// rtl/reg_array_mp.sv - multi-port register file with bypass, write priority and busy scoreboard (optional REG_ARRAY_PARITY_EN)
module reg_array_mp
  import reg_array_pkg::*;
#(
  parameter int XLEN      = XLEN_DEF,
  parameter int NUM_REGS  = NUM_REGS_DEF,
  parameter int AW        = $clog2(NUM_REGS),
  parameter int NUM_RD    = NUM_RD_DEF,
  parameter int NUM_WR    = NUM_WR_DEF,
  parameter int BYPASS_EN = 1,
  parameter int SP_INDEX  = SP_INDEX_DEF,
  parameter logic [XLEN-1:0] SP_RESET_VAL = XLEN'(SP_RESET_VAL_DEF)
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic [NUM_RD*AW-1:0]   RS_SEL,
  output logic [NUM_RD*XLEN-1:0] RS_DATAOUT,
  output logic [NUM_RD-1:0]      RS_BUSY,
  input  logic [NUM_WR-1:0]      WB_VALID,
  input  logic [NUM_WR*AW-1:0]   WB_SEL,
  input  logic [NUM_WR*XLEN-1:0] WB_DATA,
  input  logic                   ISSUE_VALID,
  input  logic [AW-1:0]          ISSUE_RD,
  input  logic                   FLUSH,
  output logic [NUM_RD-1:0]      PARITY_ERR
);

  logic [XLEN-1:0]   regs_q [NUM_REGS];
  logic [NUM_RD-1:0] rd_byp;

  // Register writes; ports applied in ascending order so the highest-numbered port wins
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == SP_INDEX) ? SP_RESET_VAL : '0;
      end
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (WB_VALID[p] && (WB_SEL[p*AW +: AW] != '0)) begin
          regs_q[WB_SEL[p*AW +: AW]] <= WB_DATA[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read mux: x0 forced to zero, else winning same-cycle write data or stored data
  always_comb begin
    logic [AW-1:0]   sel;
    logic [XLEN-1:0] data;
    logic            hit;
    RS_DATAOUT = '0;
    rd_byp     = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      sel  = RS_SEL[k*AW +: AW];
      hit  = 1'b0;
      data = regs_q[sel];
      for (int p = 0; p < NUM_WR; p++) begin
        if ((BYPASS_EN != 0) && WB_VALID[p] && (WB_SEL[p*AW +: AW] == sel)) begin
          hit  = 1'b1;
          data = WB_DATA[p*XLEN +: XLEN];
        end
      end
      if (sel == '0) begin
        hit  = 1'b0;
        data = '0;
      end
      rd_byp[k]                 = hit;
      RS_DATAOUT[k*XLEN +: XLEN] = data;
    end
  end

`ifdef REG_ARRAY_PARITY_EN
  logic [NUM_REGS-1:0] par_q;

  // Even-parity bit stored alongside each entry, tracking the same write priority
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      par_q           <= '0;
      par_q[SP_INDEX] <= ^SP_RESET_VAL;
    end else begin
      for (int p = 0; p < NUM_WR; p++) begin
        if (WB_VALID[p] && (WB_SEL[p*AW +: AW] != '0)) begin
          par_q[WB_SEL[p*AW +: AW]] <= ^WB_DATA[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Parity check only meaningful for stored, non-x0 reads
  always_comb begin
    logic [AW-1:0] sel;
    PARITY_ERR = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      sel = RS_SEL[k*AW +: AW];
      PARITY_ERR[k] = (sel != '0) && !rd_byp[k] && ((^regs_q[sel]) ^ par_q[sel]);
    end
  end
`else
  assign PARITY_ERR = '0;
`endif

  reg_array_scoreboard #(
    .NUM_REGS  (NUM_REGS),
    .AW        (AW),
    .NUM_RD    (NUM_RD),
    .NUM_WR    (NUM_WR),
    .BYPASS_EN (BYPASS_EN)
  ) u_scoreboard (
    .CLK         (CLK),
    .RST_N       (RST_N),
    .RS_SEL      (RS_SEL),
    .WB_VALID    (WB_VALID),
    .WB_SEL      (WB_SEL),
    .ISSUE_VALID (ISSUE_VALID),
    .ISSUE_RD    (ISSUE_RD),
    .FLUSH       (FLUSH),
    .RS_BUSY     (RS_BUSY)
  );

endmodule

// File: tb/tb_reg_array_mp.sv
// tb/tb_reg_array_mp.sv - randomized scoreboard bench for reg_array_mp
module tb_reg_array_mp;
  import reg_array_pkg::*;

  localparam int  NR  = 32;
  localparam bit  BYP = 1'b1;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [9:0]  RS_SEL;
  logic [63:0] RS_DATAOUT;
  logic [1:0]  RS_BUSY;
  logic [1:0]  WB_VALID;
  logic [9:0]  WB_SEL;
  logic [63:0] WB_DATA;
  logic        ISSUE_VALID;
  logic [4:0]  ISSUE_RD;
  logic        FLUSH;
  logic [1:0]  PARITY_ERR;

  always #5 CLK = ~CLK;

  reg_array_mp dut (
    .CLK(CLK), .RST_N(RST_N), .RS_SEL(RS_SEL), .RS_DATAOUT(RS_DATAOUT),
    .RS_BUSY(RS_BUSY), .WB_VALID(WB_VALID), .WB_SEL(WB_SEL), .WB_DATA(WB_DATA),
    .ISSUE_VALID(ISSUE_VALID), .ISSUE_RD(ISSUE_RD), .FLUSH(FLUSH),
    .PARITY_ERR(PARITY_ERR)
  );

  typedef struct {
    string       tag;
    logic [31:0] d [2];
    logic        b [2];
    logic        p [2];
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  // Architectural model: plain arrays of values, pending flags and corrupted-entry flags
  xdata_t mem     [NR];
  bit     pending [NR];
  bit     corrupt [NR];

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin
      mem[i] = (i == 2) ? 32'd1024 : 32'd0;
      pending[i] = 1'b0;
      corrupt[i] = 1'b0;
    end
  endfunction

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // Monitor: compare DUT outputs against the queued expectation mid-cycle
  always @(negedge CLK) begin
    if (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      for (int k = 0; k < 2; k++) begin
        check($sformatf("%s data%0d", e.tag, k), RS_DATAOUT[k*32 +: 32], e.d[k]);
        check($sformatf("%s busy%0d", e.tag, k), {31'd0, RS_BUSY[k]}, {31'd0, e.b[k]});
        check($sformatf("%s perr%0d", e.tag, k), {31'd0, PARITY_ERR[k]}, {31'd0, e.p[k]});
      end
    end
  end

  task automatic idle_inputs();
    WB_VALID = '0; WB_SEL = '0; WB_DATA = '0;
    ISSUE_VALID = 1'b0; ISSUE_RD = '0; FLUSH = 1'b0; RS_SEL = '0;
  endtask

  // One cycle: drive, predict from the model, queue, then advance the model across the edge
  task automatic step(input string tag, input logic [1:0] wv,
                      input logic [4:0] s0, input logic [31:0] d0,
                      input logic [4:0] s1, input logic [31:0] d1,
                      input logic iv, input logic [4:0] ird, input logic fl,
                      input logic [4:0] r0, input logic [4:0] r1);
    exp_t       e;
    logic [4:0] ws [2];
    logic [31:0] wd [2];
    logic [4:0] rs [2];
    ws[0] = s0; ws[1] = s1; wd[0] = d0; wd[1] = d1; rs[0] = r0; rs[1] = r1;
    WB_VALID = wv; WB_SEL = {s1, s0}; WB_DATA = {d1, d0};
    ISSUE_VALID = iv; ISSUE_RD = ird; FLUSH = fl; RS_SEL = {r1, r0};
    e.tag = tag;
    for (int k = 0; k < 2; k++) begin
      int winner;
      winner = -1;
      for (int p = 0; p < 2; p++) if (wv[p] && ws[p] == rs[k]) winner = p;
      if (rs[k] == 0) begin
        e.d[k] = 0; e.b[k] = 0; e.p[k] = 0;
      end else if (BYP && winner >= 0) begin
        e.d[k] = wd[winner]; e.b[k] = 0; e.p[k] = 0;
      end else begin
        e.d[k] = mem[rs[k]]; e.b[k] = pending[rs[k]]; e.p[k] = corrupt[rs[k]];
      end
    end
    exp_q.push_back(e);
    @(posedge CLK);
    for (int p = 0; p < 2; p++) begin
      if (wv[p] && ws[p] != 0) begin
        mem[ws[p]] = wd[p];
        corrupt[ws[p]] = 1'b0;
        pending[ws[p]] = 1'b0;
      end
    end
    if (iv && ird != 0) pending[ird] = 1'b1;
    if (fl) for (int i = 0; i < NR; i++) pending[i] = 1'b0;
    #1;
  endtask

  task automatic rd(input string tag, input logic [4:0] r0, input logic [4:0] r1);
    step(tag, 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, r0, r1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    idle_inputs();
    model_reset();
    repeat (3) @(posedge CLK);
    #1 RST_N = 1'b1;

    rd("reset", 5'd1, 5'd2);
    rd("reset_sp", 5'd2, 5'd0);

    step("conflict_byp", 2'b11, 5'd7, 32'hAAAA0000, 5'd7, 32'h5555FFFF, 1'b0, 5'd0, 1'b0, 5'd7, 5'd7);
    rd("conflict_stored", 5'd7, 5'd0);

    step("x0_write", 2'b01, 5'd0, 32'hDEADBEEF, 5'd0, 32'd0, 1'b1, 5'd0, 1'b0, 5'd0, 5'd0);
    rd("x0_read", 5'd0, 5'd0);

    step("issue5", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd5, 1'b0, 5'd5, 5'd0);
    rd("busy5", 5'd5, 5'd5);
    step("wb5_byp", 2'b01, 5'd5, 32'h12, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd5, 5'd0);
    rd("wb5_stored", 5'd5, 5'd0);
    step("iss_wb9", 2'b10, 5'd0, 32'd0, 5'd9, 32'h99, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
    rd("busy9", 5'd9, 5'd0);

    step("issue3", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd3, 1'b0, 5'd0, 5'd0);
    step("issue4", 2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b0, 5'd3, 5'd0);
    step("flush", 2'b01, 5'd11, 32'h77, 5'd0, 32'd0, 1'b1, 5'd6, 1'b1, 5'd3, 5'd4);
    rd("post_flush_a", 5'd3, 5'd4);
    rd("post_flush_b", 5'd6, 5'd11);

`ifdef REG_ARRAY_PARITY_EN
    step("par_wr10", 2'b01, 5'd10, 32'h1, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
    dut.regs_q[10] = dut.regs_q[10] ^ 32'd1;
    mem[10] = mem[10] ^ 32'd1;
    corrupt[10] = 1'b1;
    rd("par_flip", 5'd10, 5'd2);
    step("par_byp", 2'b10, 5'd0, 32'd0, 5'd10, 32'h3, 1'b0, 5'd0, 1'b0, 5'd7, 5'd10);
    rd("par_fixed", 5'd10, 5'd10);
`endif

    // Randomized traffic over a narrow index range so collisions are frequent
    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        WB_VALID = 2'($urandom); WB_SEL = 10'($urandom); WB_DATA = {$urandom, $urandom};
        ISSUE_VALID = 1'b1; ISSUE_RD = 5'($urandom); FLUSH = 1'b0;
        #1 RST_N = 1'b0;
        #1 idle_inputs();
        model_reset();
        #1 RST_N = 1'b1;
        @(posedge CLK);
        #1;
        rd("mid_reset", 5'd2, 5'($urandom_range(1, 15)));
      end else begin
        step("rand", 2'($urandom),
             5'($urandom_range(0, 15)), $urandom,
             5'($urandom_range(0, 15)), $urandom,
             1'($urandom), 5'($urandom_range(0, 15)),
             ($urandom_range(0, 15) == 0),
             5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
      end
    end

    idle_inputs();
    for (int w = 0; w < 4 && exp_q.size() != 0; w++) @(negedge CLK);
    #1;
    check("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
